// File: rtl/sdram_mem_tester.sv
// Host-side SDRAM traffic generator: writes a pattern window, reads it back, checks it.
// Optional MEMTEST_LFSR_EN swaps the address-derived pattern for an LFSR sequence.
module sdram_mem_tester #(
    parameter int                     HADDR_WIDTH     = 24,
    parameter logic [HADDR_WIDTH-1:0] START_ADDR      = HADDR_WIDTH'(24'h000000),
    parameter logic [HADDR_WIDTH-1:0] END_ADDR        = HADDR_WIDTH'(24'h0000FF),
    parameter int                     MAX_OUTSTANDING = 4,
    parameter logic [15:0]            PATTERN_XOR     = 16'hA5A5,
    parameter logic [15:0]            SEED            = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   busy,
    output logic [HADDR_WIDTH-1:0] haddr,
    output logic                   wr_enable,
    output logic [15:0]            wr_data,
    output logic                   rd_enable,
    input  logic [15:0]            rd_data,
    input  logic                   rd_rdy,
    output logic                   rd_ack,
    output logic                   done,
    output logic                   pass,
    output logic [15:0]            err_count,
    output logic [HADDR_WIDTH-1:0] first_err_addr
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t                 state_q, state_d;
    logic [HADDR_WIDTH-1:0] iss_addr_q, iss_addr_d;
    logic [HADDR_WIDTH-1:0] chk_addr_q, chk_addr_d;
    logic [HADDR_WIDTH-1:0] haddr_q, haddr_d;
    logic [HADDR_WIDTH-1:0] first_err_q, first_err_d;
    logic [15:0]            wr_data_q, wr_data_d;
    logic [15:0]            err_q, err_d;
    logic [3:0]             outst_q, outst_d;
    logic                   issue_done_q, issue_done_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   ret;
    logic [15:0]            expect_data;

`ifdef MEMTEST_LFSR_EN
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] wr_lfsr_q, wr_lfsr_d;
    logic [15:0] chk_lfsr_q, chk_lfsr_d;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    assign expect_data = chk_lfsr_q;
`else
    function automatic logic [15:0] pattern(input logic [HADDR_WIDTH-1:0] a);
        return a[15:0] ^ PATTERN_XOR;
    endfunction

    assign expect_data = pattern(chk_addr_q);
`endif

    always_comb begin
        state_d      = state_q;
        iss_addr_d   = iss_addr_q;
        chk_addr_d   = chk_addr_q;
        haddr_d      = haddr_q;
        first_err_d  = first_err_q;
        wr_data_d    = wr_data_q;
        err_d        = err_q;
        outst_d      = outst_q;
        issue_done_d = issue_done_q;
        done_d       = done_q;
        pass_d       = pass_q;
        wr_enable    = 1'b0;
        rd_enable    = 1'b0;
        rd_ack       = rd_rdy;
        ret          = 1'b0;
`ifdef MEMTEST_LFSR_EN
        wr_lfsr_d    = wr_lfsr_q;
        chk_lfsr_d   = chk_lfsr_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = WRITE;
                    iss_addr_d  = START_ADDR;
                    chk_addr_d  = START_ADDR;
                    err_d       = '0;
                    first_err_d = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
`ifdef MEMTEST_LFSR_EN
                    wr_lfsr_d   = SEED_EFF;
`endif
                end
            end
            WRITE: begin
                if (!busy) begin
                    wr_enable = 1'b1;
                    if (iss_addr_q == END_ADDR) begin
                        state_d      = READ;
                        iss_addr_d   = START_ADDR;
                        issue_done_d = 1'b0;
                        outst_d      = '0;
`ifdef MEMTEST_LFSR_EN
                        chk_lfsr_d   = SEED_EFF;
`endif
                    end else begin
                        iss_addr_d = iss_addr_q + 1'b1;
`ifdef MEMTEST_LFSR_EN
                        wr_lfsr_d  = lfsr_step(wr_lfsr_q);
`endif
                    end
                end
            end
            READ: begin
                if (!busy && !issue_done_q && (outst_q < 4'(MAX_OUTSTANDING))) begin
                    rd_enable = 1'b1;
                    if (iss_addr_q == END_ADDR) begin
                        issue_done_d = 1'b1;
                    end else begin
                        iss_addr_d = iss_addr_q + 1'b1;
                    end
                end
                // Data arriving with nothing outstanding is stray and ignored.
                if (rd_rdy && (outst_q != 4'd0)) begin
                    ret = 1'b1;
                    if (rd_data != expect_data) begin
                        if (err_q != 16'hFFFF) begin
                            err_d = err_q + 16'd1;
                        end
                        if (err_q == 16'h0000) begin
                            first_err_d = chk_addr_q;
                        end
                    end
                    if (chk_addr_q == END_ADDR) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 16'h0000);
                    end else begin
                        chk_addr_d = chk_addr_q + 1'b1;
`ifdef MEMTEST_LFSR_EN
                        chk_lfsr_d = lfsr_step(chk_lfsr_q);
`endif
                    end
                end
                outst_d = outst_q + {3'b000, rd_enable} - {3'b000, ret};
            end
            default: state_d = IDLE;
        endcase

        // haddr/wr_data are registered copies of the next issue slot.
        if (state_d == WRITE || state_d == READ) begin
            haddr_d = iss_addr_d;
        end
        if (state_d == WRITE) begin
`ifdef MEMTEST_LFSR_EN
            wr_data_d = wr_lfsr_d;
`else
            wr_data_d = pattern(iss_addr_d);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            iss_addr_q   <= '0;
            chk_addr_q   <= '0;
            haddr_q      <= '0;
            first_err_q  <= '0;
            wr_data_q    <= '0;
            err_q        <= '0;
            outst_q      <= '0;
            issue_done_q <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
`ifdef MEMTEST_LFSR_EN
            wr_lfsr_q    <= '0;
            chk_lfsr_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            iss_addr_q   <= iss_addr_d;
            chk_addr_q   <= chk_addr_d;
            haddr_q      <= haddr_d;
            first_err_q  <= first_err_d;
            wr_data_q    <= wr_data_d;
            err_q        <= err_d;
            outst_q      <= outst_d;
            issue_done_q <= issue_done_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
`ifdef MEMTEST_LFSR_EN
            wr_lfsr_q    <= wr_lfsr_d;
            chk_lfsr_q   <= chk_lfsr_d;
`endif
        end
    end

    assign haddr          = haddr_q;
    assign wr_data        = wr_data_q;
    assign err_count      = err_q;
    assign first_err_addr = first_err_q;
    assign done           = done_q;
    assign pass           = pass_q;

endmodule

// File: tb/tb_sdram_mem_tester.sv
// Bench for sdram_mem_tester: table of full runs against a small memory model,
// plus hand sequences for reset, stray data, saturation and mid-run reset.
module tb_sdram_mem_tester;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy = 1'b0;
    logic [23:0] haddr;
    logic        wr_enable;
    logic [15:0] wr_data;
    logic        rd_enable;
    logic [15:0] rd_data;
    logic        rd_rdy;
    logic        rd_ack;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [23:0] first_err_addr;

    always #5 clk = ~clk;

    sdram_mem_tester #(
        .HADDR_WIDTH(24),
        .START_ADDR(24'h000000),
        .END_ADDR(24'h0000FF),
        .MAX_OUTSTANDING(4),
        .PATTERN_XOR(16'hA5A5),
        .SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .busy(busy),
        .haddr(haddr),
        .wr_enable(wr_enable),
        .wr_data(wr_data),
        .rd_enable(rd_enable),
        .rd_data(rd_data),
        .rd_rdy(rd_rdy),
        .rd_ack(rd_ack),
        .done(done),
        .pass(pass),
        .err_count(err_count),
        .first_err_addr(first_err_addr)
    );

    int nchk = 0;
    int nerr = 0;

    function automatic logic [15:0] exp_pat(input int a);
`ifdef MEMTEST_LFSR_EN
        logic [15:0] l;
        l = 16'hACE1;
        for (int i = 0; i < a; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        return l;
`else
        return 16'(a) ^ 16'hA5A5;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: read requests become visible 'lat' cycles after issue.
    typedef struct {
        int     a;
        longint t;
    } req_t;

    logic [15:0] mem [256];
    req_t        q[$];
    longint      cyc = 0;
    int          mode = 0;
    int          lat = 1;
    logic        m_rdy = 1'b0;
    logic [15:0] m_data = '0;
    logic        stray = 1'b0;

    int          wcnt = 0;
    int          rcnt = 0;
    int          exp_w = 0;
    int          seq_bad = 0;
    int          out_cnt = 0;
    int          max_out = 0;
    logic [15:0] first4 [4];

    assign rd_rdy  = m_rdy | stray;
    assign rd_data = stray ? 16'hDEAD : m_data;

    function automatic logic [15:0] model_read(input int a);
        case (mode)
            1:       return mem[a] ^ ((a == 2) ? 16'h0001 : 16'h0000);
            2:       return 16'h0000;
            default: return mem[a];
        endcase
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            q.delete();
            m_rdy   <= 1'b0;
            out_cnt <= 0;
        end else begin
            if (wr_enable) mem[haddr[7:0]] <= wr_data;
            if (rd_enable) q.push_back('{int'(haddr[7:0]), cyc + longint'(lat)});
            if (m_rdy) void'(q.pop_front());
            m_rdy   <= (q.size() != 0) && (q[0].t <= cyc + 1);
            m_data  <= (q.size() != 0) ? model_read(q[0].a) : 16'h0000;
            out_cnt <= out_cnt + int'(rd_enable) - int'(m_rdy);
            max_out <= (out_cnt > max_out) ? out_cnt : max_out;
        end
        if (start) begin
            wcnt    <= 0;
            rcnt    <= 0;
            exp_w   <= 0;
            seq_bad <= 0;
            max_out <= 0;
        end else begin
            if (wr_enable) begin
                if (wcnt < 4) first4[wcnt] <= wr_data;
                wcnt  <= wcnt + 1;
                exp_w <= exp_w + 1;
                if (haddr != 24'(exp_w) || wr_data != exp_pat(exp_w)) seq_bad <= seq_bad + 1;
            end
            if (rd_enable) rcnt <= rcnt + 1;
        end
    end

    typedef struct {
        string       name;
        int          mode;
        int          lat;
        bit          stall;
        bit          exp_pass;
        logic [15:0] exp_err;
        logic [23:0] exp_first;
        int          exp_maxout;
    } vec_t;

    vec_t vecs[5];

    task automatic do_run(input vec_t v);
        int n;
        int stall_bad;
        bit stalled;
        mode = v.mode;
        lat  = v.lat;
        stall_bad = 0;
        stalled = 1'b0;
        n = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        while (!done && n < 5000) begin
            if (v.stall && !stalled && wr_enable && haddr == 24'd1) begin
                busy = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    #1;
                    if (wr_enable || haddr != 24'd1 || wr_data != exp_pat(1)) stall_bad++;
                    @(negedge clk);
                end
                busy = 1'b0;
                stalled = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        chk({v.name, " timeout"}, 32'(n < 5000), 32'd1);
        chk({v.name, " done"}, 32'(done), 32'd1);
        chk({v.name, " pass"}, 32'(pass), 32'(v.exp_pass));
        chk({v.name, " err_count"}, 32'(err_count), 32'(v.exp_err));
        chk({v.name, " first_err_addr"}, 32'(first_err_addr), 32'(v.exp_first));
        chk({v.name, " writes"}, 32'(wcnt), 32'd256);
        chk({v.name, " reads"}, 32'(rcnt), 32'd256);
        chk({v.name, " write_seq"}, 32'(seq_bad), 32'd0);
        chk({v.name, " max_outstanding<=4"}, 32'(max_out <= 4), 32'd1);
        if (v.exp_maxout >= 0) chk({v.name, " max_outstanding"}, 32'(max_out), 32'(v.exp_maxout));
        if (v.stall) begin
            chk({v.name, " stall_used"}, 32'(stalled), 32'd1);
            chk({v.name, " stall_hold"}, 32'(stall_bad), 32'd0);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " haddr"}, 32'(haddr), 32'd0);
        chk({tag, " wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, " enables"}, {29'd0, wr_enable, rd_enable, rd_ack}, 32'd0);
        chk({tag, " done/pass"}, {30'd0, done, pass}, 32'd0);
        chk({tag, " err_count"}, 32'(err_count), 32'd0);
        chk({tag, " first_err_addr"}, 32'(first_err_addr), 32'd0);
    endtask

    initial begin
        int n;
        vecs[0] = '{"clean", 0, 1, 1'b0, 1'b1, 16'h0000, 24'h000000, -1};
        vecs[1] = '{"flip2", 1, 1, 1'b0, 1'b0, 16'h0001, 24'h000002, -1};
        vecs[2] = '{"stall", 0, 1, 1'b1, 1'b1, 16'h0000, 24'h000000, -1};
        vecs[3] = '{"lat20", 0, 20, 1'b0, 1'b1, 16'h0000, 24'h000000, 4};
        vecs[4] = '{"stuck", 2, 1, 1'b0, 1'b0, 16'h0100, 24'h000000, -1};

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            do_run(vecs[i]);
            if (i == 0) begin
`ifdef MEMTEST_LFSR_EN
                chk("lfsr first wr_data", 32'(first4[0]), 32'h0000ACE1);
`else
                chk("wr_data[0]", 32'(first4[0]), 32'h0000A5A5);
                chk("wr_data[1]", 32'(first4[1]), 32'h0000A5A4);
                chk("wr_data[2]", 32'(first4[2]), 32'h0000A5A7);
                chk("wr_data[3]", 32'(first4[3]), 32'h0000A5A6);
`endif
            end
        end

        // Stray data while DONE is popped and ignored.
        stray = 1'b1;
        #1;
        chk("stray rd_ack", 32'(rd_ack), 32'd1);
        @(negedge clk);
        @(negedge clk);
        stray = 1'b0;
        #1;
        chk("stray err_count", 32'(err_count), 32'h0100);
        chk("stray done", 32'(done), 32'd1);

        // Saturation: preload the counter near the top mid-run.
        mode = 2;
        lat = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (err_count < 16'd3 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("sat reach", 32'(n < 2000), 32'd1);
        force dut.err_q = 16'hFFFD;
        #1;
        release dut.err_q;
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("sat done", 32'(done), 32'd1);
        chk("sat err_count", 32'(err_count), 32'h0000FFFF);
        chk("sat first_err_addr", 32'(first_err_addr), 32'd0);
        @(negedge clk);
        chk("sat hold", 32'(err_count), 32'h0000FFFF);

        // Reset during READ, then a fresh clean run.
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!rd_enable && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("midread reach", 32'(n < 2000), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_zero("midread reset");
        rst = 1'b0;
        do_run(vecs[0]);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
